// File: rtl/jtag_chain1.sv
// ER1 user-data JTAG chain: 36-bit frames (4-bit opcode + 32-bit payload) program
// bus-master configuration registers and select a read-back word for the next scan.
module jtag_chain1 (
    input  logic        JTCK,
    input  logic        JRSTN,
    input  logic        JTDI,
    input  logic        JRTI1,
    input  logic        JSHIFT,
    input  logic        JUPDATE,
    input  logic        JCE1,
    output logic        JTD1,
    input  logic [31:0] pp_dataOut,
    input  logic        switch_ready
);

    typedef enum logic [3:0] {
        OP_NOP      = 4'b0000,
        OP_WR_ADDR  = 4'b0001,
        OP_WR_BE    = 4'b0010,
        OP_WR_BURST = 4'b0011,
        OP_RD_ADDR  = 4'b0100,
        OP_RD_BE    = 4'b0101,
        OP_RD_BURST = 4'b0110,
        OP_RD_BUS   = 4'b0111
    } opcode_t;

    logic [35:0] shift_reg;
    logic [31:0] address_reg;
    logic [3:0]  byte_enable_reg;
    logic [7:0]  burst_size_reg;
    logic [7:0]  status_reg;
    logic [3:0]  response_sel;
    logic [31:0] response_data;
    logic [3:0]  op;
    logic [31:0] pl;

    assign op   = shift_reg[3:0];
    assign pl   = shift_reg[35:4];
    assign JTD1 = shift_reg[0];

    // Run-test-idle and the last-opcode history are not consumed by this chain.
    logic [4:0] unused_sig;
    assign unused_sig = {JRTI1, status_reg[7:4]};

    always_comb begin
        response_data = 32'b0;
        case (response_sel)
            OP_RD_ADDR:  response_data = address_reg;
            OP_RD_BE:    response_data = {28'b0, byte_enable_reg};
            OP_RD_BURST: response_data = {24'b0, burst_size_reg};
            OP_RD_BUS:   response_data = pp_dataOut;
            default:     response_data = 32'b0;
        endcase
    end

    always_ff @(posedge JTCK) begin
        if (!JRSTN) begin
            shift_reg       <= '0;
            address_reg     <= '0;
            byte_enable_reg <= '0;
            burst_size_reg  <= '0;
            status_reg      <= '0;
            response_sel    <= '0;
        end else begin
            status_reg[3] <= switch_ready;
            // Update wins over any concurrent capture/shift so the decoded frame stays intact.
            if (JUPDATE) begin
                status_reg[7:4] <= op;
                case (op)
                    OP_WR_ADDR: begin
                        address_reg   <= pl;
                        status_reg[0] <= 1'b1;
                    end
                    OP_WR_BE: begin
                        byte_enable_reg <= pl[3:0];
                        status_reg[1]   <= 1'b1;
                    end
                    OP_WR_BURST: begin
                        burst_size_reg <= pl[7:0];
                        status_reg[2]  <= 1'b1;
                    end
                    OP_RD_ADDR, OP_RD_BE, OP_RD_BURST, OP_RD_BUS: response_sel <= op;
                    OP_NOP:  response_sel <= 4'b0000;
                    default: ;
                endcase
            end else if (JCE1) begin
                if (JSHIFT) shift_reg <= {JTDI, shift_reg[35:1]};
                else        shift_reg <= {response_data, status_reg[3:0]};
            end
        end
    end

endmodule

// File: tb/tb_jtag_chain1.sv
// Randomized bench for jtag_chain1: every scan's shifted-out word is compared with a
// transaction-level model of the configuration registers and read selector.
module tb_jtag_chain1;

    logic        JTCK = 1'b0;
    logic        JRSTN = 1'b0;
    logic        JTDI = 1'b0;
    logic        JRTI1 = 1'b0;
    logic        JSHIFT = 1'b0;
    logic        JUPDATE = 1'b0;
    logic        JCE1 = 1'b0;
    logic        JTD1;
    logic [31:0] pp_dataOut = 32'b0;
    logic        switch_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    // Model state
    logic [31:0] m_addr;
    logic [3:0]  m_be;
    logic [7:0]  m_bs;
    logic [2:0]  m_sticky;
    logic [3:0]  m_sel;
    logic [35:0] m_frame;

    jtag_chain1 dut (
        .JTCK(JTCK), .JRSTN(JRSTN), .JTDI(JTDI), .JRTI1(JRTI1), .JSHIFT(JSHIFT),
        .JUPDATE(JUPDATE), .JCE1(JCE1), .JTD1(JTD1), .pp_dataOut(pp_dataOut),
        .switch_ready(switch_ready)
    );

    always #5 JTCK = ~JTCK;

    task automatic check(input string tag, input logic [35:0] got, input logic [35:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge JTCK);
        #1;
    endtask

    function automatic void m_reset();
        m_addr = 0; m_be = 0; m_bs = 0; m_sticky = 0; m_sel = 0; m_frame = 0;
    endfunction

    function automatic void m_decode();
        logic [3:0]  op = m_frame[3:0];
        logic [31:0] pl = m_frame[35:4];
        if (op == 4'd1) begin m_addr = pl; m_sticky[0] = 1'b1; end
        else if (op == 4'd2) begin m_be = pl[3:0]; m_sticky[1] = 1'b1; end
        else if (op == 4'd3) begin m_bs = pl[7:0]; m_sticky[2] = 1'b1; end
        else if (op >= 4'd4 && op <= 4'd7) m_sel = op;
        else if (op == 4'd0) m_sel = 4'd0;
    endfunction

    function automatic logic [31:0] m_resp(input logic [31:0] pp);
        if (m_sel == 4'd4) return m_addr;
        if (m_sel == 4'd5) return 32'(m_be);
        if (m_sel == 4'd6) return 32'(m_bs);
        if (m_sel == 4'd7) return pp;
        return 32'b0;
    endfunction

    // One full DR scan; returns the 36 bits observed on JTD1 and checks them.
    task automatic scan(input string tag, input logic [35:0] frame, input logic sr,
                        input logic [31:0] pp, output logic [35:0] got);
        logic [35:0] exp;
        switch_ready = sr;
        pp_dataOut   = pp;
        JCE1 = 1'b0; JSHIFT = 1'b0;
        tick();
        exp = {m_resp(pp), sr, m_sticky};
        JCE1 = 1'b1;
        tick();
        JSHIFT = 1'b1;
        for (int i = 0; i < 36; i++) begin
            got[i] = JTD1;
            JTDI = frame[i];
            tick();
        end
        JCE1 = 1'b0; JSHIFT = 1'b0; JTDI = 1'b0;
        tick();
        m_frame = frame;
        check(tag, got, exp);
    endtask

    task automatic update();
        JUPDATE = 1'b1;
        tick();
        JUPDATE = 1'b0;
        m_decode();
    endtask

    task automatic do_reset();
        JRSTN = 1'b0; JCE1 = 1'b0; JSHIFT = 1'b0; JUPDATE = 1'b0;
        tick();
        tick();
        JRSTN = 1'b1;
        m_reset();
    endtask

    initial begin
        logic [35:0] got;
        logic [35:0] frame;
        logic [3:0]  op;
        int          pick;

        m_reset();
        do_reset();
        check("rst_jtd1", 36'(JTD1), 36'd0);
        scan("rst_readback", 36'd0, 1'b0, 32'hDEADBEEF, got);

        // Directed register writes and read-backs
        scan("wr_addr", 36'h555555551, 1'b1, 32'h0, got); update();
        check("addr_sticky", 36'(dut.status_reg), 36'h19);
        scan("wr_be", 36'b11100010, 1'b1, 32'h0, got); update();
        scan("wr_bs", 36'b10101010011, 1'b1, 32'h0, got); update();
        scan("sel_addr", 36'b100, 1'b1, 32'h0, got); update();
        check("sel_addr_sticky", got[3:0], 36'hF);
        scan("rd_addr", 36'b101, 1'b1, 32'h0, got); update();
        check("rd_addr_val", {got[35:4], got[3:0]}, {32'h55555555, 4'b1111});
        scan("rd_be", 36'b110, 1'b1, 32'h0, got); update();
        check("rd_be_val", got, {28'b0, 4'b1110, 4'b1111});
        scan("rd_bs", 36'b111, 1'b0, 32'h0, got); update();
        check("rd_bs_val", got, {24'b0, 8'h55, 4'b0111});
        scan("rd_bus", 36'b0, 1'b1, 32'hFFFFFFFF, got); update();
        check("rd_bus_val", got[35:4], 36'hFFFFFFFF);
        scan("unk_op", 36'hABCDEF01F, 1'b1, 32'h0, got); update();
        scan("unk_sel", 36'b100, 1'b1, 32'h0, got); update();
        scan("unk_addr", 36'b0, 1'b1, 32'h0, got); update();
        check("unk_addr_val", got[35:4], 36'h55555555);

        // Update concurrent with a shift: shift_reg must hold, so a stale re-update
        // re-decodes the same byte-enable write instead of a shifted frame.
        scan("both_ld", {32'h0000000A, 4'h2}, 1'b0, 32'h0, got);
        JCE1 = 1'b1; JSHIFT = 1'b1; JUPDATE = 1'b1; JTDI = 1'b1;
        tick();
        JCE1 = 1'b0; JSHIFT = 1'b0; JUPDATE = 1'b0; JTDI = 1'b0;
        m_decode();
        update();
        scan("both_sel", 36'b100, 1'b0, 32'h0, got); update();
        scan("both_addr", 36'b101, 1'b0, 32'h0, got); update();
        check("both_addr_val", got[35:4], 36'h55555555);
        scan("both_be", 36'b0, 1'b0, 32'h0, got); update();
        check("both_be_val", got[35:4], 36'hA);

        // Reset in the middle of a scan aborts it
        JCE1 = 1'b1; tick(); JSHIFT = 1'b1;
        for (int i = 0; i < 7; i++) begin JTDI = 1'b1; tick(); end
        JRSTN = 1'b0; tick(); JRSTN = 1'b1;
        JCE1 = 1'b0; JSHIFT = 1'b0; JTDI = 1'b0;
        m_reset();
        check("rst_mid_jtd1", 36'(JTD1), 36'd0);
        scan("rst_mid_rb", 36'b100, 1'b1, 32'h0, got); update();
        scan("rst_mid_addr", 36'b0, 1'b0, 32'h0, got); update();

        // Randomized frames against the model
        for (int n = 0; n < 80; n++) begin
            pick = $urandom_range(0, 10);
            if (pick <= 7) op = 4'(pick);
            else if (pick == 8) op = 4'hF;
            else op = 4'($urandom);
            frame = {32'($urandom), op};
            scan("rnd", frame, 1'($urandom), 32'($urandom), got);
            if ($urandom_range(0, 9) == 0) begin
                JCE1 = 1'b1; JSHIFT = 1'b1; JUPDATE = 1'b1; JTDI = 1'($urandom);
                tick();
                JCE1 = 1'b0; JSHIFT = 1'b0; JUPDATE = 1'b0; JTDI = 1'b0;
                m_decode();
            end
            update();
            if ($urandom_range(0, 4) == 0) update();
            if ($urandom_range(0, 24) == 0) begin
                do_reset();
                check("rnd_rst_jtd1", 36'(JTD1), 36'd0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
